glb_fifo_rr_ctrl: RTL and testbench

Parametrised successor to the per-channel ifmap/ipsum/opsum FIFO controllers in the token engine. One instance serves CH FIFOs of one data class through a single shared GLB port, chosen by the DIR parameter as read (ifmap/ipsum fill) or write (opsum drain). A round-robin arbiter issues one GLB request per cycle and honours GLB back-pressure. Per-channel address counters walk a strided GLB region, and the block reports busy and done for the L2 tile sequencer.

---
 rtl/glb_fifo_rr_ctrl_pkg.sv | 27 ++
 rtl/glb_fifo_rr_ctrl_if.sv | 28 ++
 rtl/glb_fifo_rr_ctrl_arb.sv | 56 +++++
 rtl/glb_fifo_rr_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_glb_fifo_rr_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glb_fifo_rr_ctrl_pkg.sv
// Shared definitions for the token-engine FIFO/GLB controllers.
//   state_e        : controller FSM states
//   dir_e          : transfer direction (GLB->FIFO read, FIFO->GLB write)
//   GLB_WORD_BYTES : GLB word size in bytes (address step per word)
//   WEB_NONE       : inactive (active-low) byte write-enable pattern
//   id_width()     : width of a channel index, at least 1 bit
package token_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

    localparam int unsigned GLB_WORD_BYTES = 4;
    localparam logic [3:0]  WEB_NONE       = 4'hF;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glb_fifo_rr_ctrl_if.sv
// Shared GLB port bundle between the FIFO controller and the GLB.
//   glb_req   : request valid           (master -> slave)
//   glb_we    : 1 = write, 0 = read     (master -> slave)
//   glb_addr  : byte address            (master -> slave)
//   glb_web   : active-low byte enables (master -> slave)
//   glb_ch_id : requesting channel      (master -> slave)
//   glb_ready : request accepted        (slave -> master)
interface glb_fifo_rr_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 5
);
    logic              glb_req;
    logic              glb_we;
    logic [ADDR_W-1:0] glb_addr;
    logic [3:0]        glb_web;
    logic [ID_W-1:0]   glb_ch_id;
    logic              glb_ready;

    modport master (
        output glb_req, glb_we, glb_addr, glb_web, glb_ch_id,
        input  glb_ready
    );

    modport slave (
        input  glb_req, glb_we, glb_addr, glb_web, glb_ch_id,
        output glb_ready
    );
endinterface

// File: rtl/glb_fifo_rr_ctrl_arb.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index for this cycle (held by the parent)
//   gnt    : one-hot grant
//   gnt_id : index of the granted request (0 when none)
//   any    : at least one request is granted
module rr_arbiter
    import token_fifo_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    // Two passes: first request at or above ptr wins, else the lowest
    // request overall (the wrap-around part of the rotation).
    always_comb begin
        int unsigned sel;
        logic        hi_any;
        logic        lo_any;
        int unsigned hi_id;
        int unsigned lo_id;

        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_id  = 0;
        lo_id  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hi_any && req[i] && (i >= 32'(ptr))) begin
                hi_any = 1'b1;
                hi_id  = i;
            end
            if (!lo_any && req[i]) begin
                lo_any = 1'b1;
                lo_id  = i;
            end
        end

        any    = hi_any || lo_any;
        sel    = hi_any ? hi_id : lo_id;
        gnt    = '0;
        gnt_id = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (any && (i == sel)) begin
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/glb_fifo_rr_ctrl.sv
// Round-robin controller moving words between CH FIFOs and one GLB port.
// DIR=0: GLB read -> FIFO push (data valid one cycle after accept).
// DIR=1: FIFO pop -> GLB write (first-word-fall-through FIFO heads).
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : latch config and run (ignored while busy)
//   base_addr         : byte address of channel 0, word 0
//   ch_stride         : byte distance between channel regions
//   ch_len            : words per enabled channel
//   ch_en             : channel enable mask
//   permit            : per-channel L2 permission
//   fifo_full/empty   : FIFO status (full used for DIR=0, empty for DIR=1)
//   fifo_reset_i/_o   : per-channel flush request / pass-through
//   web_i             : per-channel active-low byte enables (4 per channel)
//   glb               : GLB request port (master side)
//   fifo_push_en      : one-hot push strobe (DIR=0)
//   fifo_pop_en       : one-hot pop strobe (DIR=1)
//   busy, done        : run status and one-cycle completion pulse
module glb_fifo_rr_ctrl
    import token_fifo_pkg::*;
#(
    parameter int unsigned CH     = 32,
    parameter int unsigned DIR    = 0,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   ch_stride,
    input  logic [LEN_W-1:0]    ch_len,
    input  logic [CH-1:0]       ch_en,
    input  logic [CH-1:0]       permit,
    input  logic [CH-1:0]       fifo_full,
    input  logic [CH-1:0]       fifo_empty,
    input  logic [CH-1:0]       fifo_reset_i,
    input  logic [CH*4-1:0]     web_i,
    glb_fifo_rr_ctrl_if.master  glb,
    output logic [CH-1:0]       fifo_push_en,
    output logic [CH-1:0]       fifo_pop_en,
    output logic [CH-1:0]       fifo_reset_o,
    output logic                busy,
    output logic                done
);

    localparam int unsigned ID_W  = id_width(CH);
    localparam dir_e        DIR_E = (DIR == 0) ? DIR_RD : DIR_WR;
    localparam bit          IS_WR = (DIR_E == DIR_WR);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  stride_q, stride_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CH-1:0]      en_q, en_d;
    logic [CH-1:0]      inflight_q, inflight_d;
    logic [LEN_W-1:0]   cnt_q [CH];
    logic [LEN_W-1:0]   cnt_d [CH];
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [CH-1:0]      elig;
    logic [CH-1:0]      gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               any;
    logic               accept;
    logic               all_done;
    logic [LEN_W-1:0]   cnt_sel;
    logic [3:0]         web_sel;
    logic [ADDR_W-1:0]  addr_c;

    always_comb begin
        elig     = '0;
        all_done = 1'b1;
        for (int unsigned i = 0; i < CH; i++) begin
            elig[i] = (state_q == ST_RUN) && en_q[i] && (cnt_q[i] < len_q)
                   && permit[i] && !fifo_reset_i[i]
                   && (IS_WR ? !fifo_empty[i]
                             : (!fifo_full[i] && !inflight_q[i]));
            if (en_q[i] && (cnt_q[i] != len_q)) begin
                all_done = 1'b0;
            end
        end
    end

    rr_arbiter #(
        .N    (CH),
        .ID_W (ID_W)
    ) u_arb (
        .req    (elig),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    always_comb begin
        cnt_sel = '0;
        web_sel = WEB_NONE;
        for (int unsigned i = 0; i < CH; i++) begin
            if (gnt[i]) begin
                cnt_sel = cnt_q[i];
                web_sel = web_i[i*4 +: 4];
            end
        end
    end

    assign addr_c = base_q
                  + (ADDR_W'(gnt_id) * stride_q)
                  + (ADDR_W'(cnt_sel) * ADDR_W'(GLB_WORD_BYTES));

    assign accept         = any && glb.glb_ready;
    assign glb.glb_req    = any;
    assign glb.glb_we     = IS_WR;
    assign glb.glb_addr   = any ? addr_c : '0;
    assign glb.glb_ch_id  = any ? gnt_id : '0;
    assign glb.glb_web    = (IS_WR && any) ? web_sel : WEB_NONE;

    assign fifo_pop_en    = (IS_WR && accept) ? gnt : '0;
    // inflight_q doubles as the registered push strobe; a flush arriving in
    // the push cycle masks it so stale read data never enters the FIFO.
    assign fifo_push_en   = inflight_q & ~fifo_reset_i;
    assign fifo_reset_o   = fifo_reset_i;
    assign busy           = busy_q;
    assign done           = done_q;

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        base_d     = base_q;
        stride_d   = stride_q;
        len_d      = len_q;
        en_d       = en_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        inflight_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    base_d   = base_addr;
                    stride_d = ch_stride;
                    len_d    = ch_len;
                    en_d     = ch_en;
                    for (int unsigned i = 0; i < CH; i++) begin
                        cnt_d[i] = '0;
                    end
                end
            end
            ST_RUN: begin
                if (all_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            rr_ptr_d = (gnt_id == ID_W'(CH - 1)) ? '0 : gnt_id + ID_W'(1);
            for (int unsigned i = 0; i < CH; i++) begin
                if (gnt[i]) begin
                    cnt_d[i] = cnt_q[i] + LEN_W'(1);
                    if (!IS_WR) begin
                        inflight_d[i] = 1'b1;
                    end
                end
            end
        end

        for (int unsigned i = 0; i < CH; i++) begin
            if (fifo_reset_i[i]) begin
                cnt_d[i]      = '0;
                inflight_d[i] = 1'b0;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            base_q     <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            en_q       <= '0;
            inflight_q <= '0;
            rr_ptr_q   <= '0;
            for (int unsigned i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            en_q       <= en_d;
            inflight_q <= inflight_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_glb_fifo_rr_ctrl.sv
module tb_glb_fifo_rr_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // DUT A: DIR=0 (GLB read -> FIFO push), 4 channels
    logic        a_start;
    logic [31:0] a_base, a_stride;
    logic [15:0] a_len;
    logic [3:0]  a_en, a_permit, a_full, a_empty, a_rst_i;
    logic [15:0] a_web;
    logic [3:0]  a_push, a_pop, a_rst_o;
    logic        a_busy, a_done;

    glb_fifo_rr_ctrl_if #(.ADDR_W(32), .ID_W(2)) a_if ();

    glb_fifo_rr_ctrl #(.CH(4), .DIR(0), .ADDR_W(32), .LEN_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .base_addr(a_base), .ch_stride(a_stride), .ch_len(a_len),
        .ch_en(a_en), .permit(a_permit), .fifo_full(a_full),
        .fifo_empty(a_empty), .fifo_reset_i(a_rst_i), .web_i(a_web),
        .glb(a_if.master), .fifo_push_en(a_push), .fifo_pop_en(a_pop),
        .fifo_reset_o(a_rst_o), .busy(a_busy), .done(a_done)
    );

    // DUT B: DIR=1 (FIFO pop -> GLB write), 2 channels
    logic        b_start;
    logic [31:0] b_base, b_stride;
    logic [15:0] b_len;
    logic [1:0]  b_en, b_permit, b_full, b_empty, b_rst_i;
    logic [7:0]  b_web;
    logic [1:0]  b_push, b_pop, b_rst_o;
    logic        b_busy, b_done;

    glb_fifo_rr_ctrl_if #(.ADDR_W(32), .ID_W(1)) b_if ();

    glb_fifo_rr_ctrl #(.CH(2), .DIR(1), .ADDR_W(32), .LEN_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .base_addr(b_base), .ch_stride(b_stride), .ch_len(b_len),
        .ch_en(b_en), .permit(b_permit), .fifo_full(b_full),
        .fifo_empty(b_empty), .fifo_reset_i(b_rst_i), .web_i(b_web),
        .glb(b_if.master), .fifo_push_en(b_push), .fifo_pop_en(b_pop),
        .fifo_reset_o(b_rst_o), .busy(b_busy), .done(b_done)
    );

    task automatic set_defaults;
        a_start = 0; a_base = 0; a_stride = 0; a_len = 0; a_en = 0;
        a_permit = 4'hF; a_full = 0; a_empty = 0; a_rst_i = 0; a_web = 0;
        a_if.glb_ready = 1'b1;
        b_start = 0; b_base = 0; b_stride = 0; b_len = 0; b_en = 0;
        b_permit = 2'b11; b_full = 0; b_empty = 0; b_rst_i = 0; b_web = 0;
        b_if.glb_ready = 1'b1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        set_defaults();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Leaves the caller 1 time unit after the negedge of cycle start+1.
    task automatic a_go(input logic [31:0] base, input logic [31:0] stride,
                        input logic [15:0] len, input logic [3:0] en);
        @(negedge clk);
        a_base = base; a_stride = stride; a_len = len; a_en = en;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        #1;
    endtask

    task automatic b_go(input logic [31:0] base, input logic [31:0] stride,
                        input logic [15:0] len, input logic [1:0] en);
        @(negedge clk);
        b_base = base; b_stride = stride; b_len = len; b_en = en;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_chk++; if (a_if.glb_req !== 1'b0) begin n_fail++; $display("FAIL rst_a_req got=%0h exp=0", a_if.glb_req); end
        n_chk++; if (a_if.glb_addr !== 32'h0) begin n_fail++; $display("FAIL rst_a_addr got=%0h exp=0", a_if.glb_addr); end
        n_chk++; if (a_if.glb_ch_id !== 2'd0) begin n_fail++; $display("FAIL rst_a_id got=%0h exp=0", a_if.glb_ch_id); end
        n_chk++; if (a_if.glb_web !== 4'hF) begin n_fail++; $display("FAIL rst_a_web got=%0h exp=f", a_if.glb_web); end
        n_chk++; if (a_if.glb_we !== 1'b0) begin n_fail++; $display("FAIL rst_a_we got=%0h exp=0", a_if.glb_we); end
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_busy got=%0h exp=0", a_busy); end
        n_chk++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rst_a_done got=%0h exp=0", a_done); end
        n_chk++; if (a_push !== 4'h0) begin n_fail++; $display("FAIL rst_a_push got=%0h exp=0", a_push); end
        n_chk++; if (a_pop !== 4'h0) begin n_fail++; $display("FAIL rst_a_pop got=%0h exp=0", a_pop); end
        n_chk++; if (b_if.glb_req !== 1'b0) begin n_fail++; $display("FAIL rst_b_req got=%0h exp=0", b_if.glb_req); end
        n_chk++; if (b_if.glb_we !== 1'b1) begin n_fail++; $display("FAIL rst_b_we got=%0h exp=1", b_if.glb_we); end
        n_chk++; if (b_if.glb_web !== 4'hF) begin n_fail++; $display("FAIL rst_b_web got=%0h exp=f", b_if.glb_web); end
        n_chk++; if (b_pop !== 2'b00) begin n_fail++; $display("FAIL rst_b_pop got=%0h exp=0", b_pop); end
        a_rst_i = 4'b0110; b_rst_i = 2'b10;
        #1;
        n_chk++; if (a_rst_o !== 4'b0110) begin n_fail++; $display("FAIL rst_passthru_a got=%0h exp=6", a_rst_o); end
        n_chk++; if (b_rst_o !== 2'b10) begin n_fail++; $display("FAIL rst_passthru_b got=%0h exp=2", b_rst_o); end
        a_rst_i = 0; b_rst_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill;
        logic [31:0] exp_addr [8] = '{32'h1000, 32'h1100, 32'h1200, 32'h1300,
                                      32'h1004, 32'h1104, 32'h1204, 32'h1304};
        int          exp_ch   [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int          k = 0;
        int          dones = 0;
        logic        prev_acc = 1'b0;
        logic [3:0]  exp_push;
        do_reset();
        a_go(32'h1000, 32'h100, 16'd2, 4'hF);
        n_chk++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy_start1 got=%0h exp=1", a_busy); end
        n_chk++; if (a_if.glb_req !== 1'b1) begin n_fail++; $display("FAIL fill_req_start1 got=%0h exp=1", a_if.glb_req); end
        for (int c = 0; c < 20; c++) begin
            exp_push = prev_acc ? (4'b0001 << exp_ch[k-1]) : 4'b0000;
            n_chk++; if (a_push !== exp_push) begin n_fail++; $display("FAIL fill_push c=%0d got=%0h exp=%0h", c, a_push, exp_push); end
            prev_acc = 1'b0;
            if (a_if.glb_req && a_if.glb_ready) begin
                n_chk++;
                if (k >= 8) begin
                    n_fail++; $display("FAIL fill_extra_accept c=%0d got=%0h exp=none", c, a_if.glb_addr);
                end else if (a_if.glb_addr !== exp_addr[k] || a_if.glb_ch_id !== 2'(exp_ch[k])) begin
                    n_fail++; $display("FAIL fill_accept k=%0d got=%0h/%0d exp=%0h/%0d", k, a_if.glb_addr, a_if.glb_ch_id, exp_addr[k], exp_ch[k]);
                end
                if (k < 8) prev_acc = 1'b1;
                k++;
            end
            if (a_done) dones++;
            @(negedge clk); #1;
        end
        n_chk++; if (k !== 8) begin n_fail++; $display("FAIL fill_accept_count got=%0d exp=8", k); end
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL fill_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_ready_stall;
        int seen = 0;
        do_reset();
        a_if.glb_ready = 1'b0;
        a_go(32'h1000, 32'h100, 16'd2, 4'b0001);
        for (int c = 0; c < 5; c++) begin
            n_chk++; if (a_if.glb_req !== 1'b1) begin n_fail++; $display("FAIL stall_req c=%0d got=%0h exp=1", c, a_if.glb_req); end
            n_chk++; if (a_if.glb_addr !== 32'h1000) begin n_fail++; $display("FAIL stall_addr c=%0d got=%0h exp=1000", c, a_if.glb_addr); end
            n_chk++; if (a_if.glb_ch_id !== 2'd0) begin n_fail++; $display("FAIL stall_id c=%0d got=%0h exp=0", c, a_if.glb_ch_id); end
            n_chk++; if (a_push !== 4'h0) begin n_fail++; $display("FAIL stall_push c=%0d got=%0h exp=0", c, a_push); end
            @(negedge clk);
            if (c == 4) a_if.glb_ready = 1'b1;
            #1;
        end
        n_chk++; if (a_if.glb_addr !== 32'h1000) begin n_fail++; $display("FAIL stall_release_addr got=%0h exp=1000", a_if.glb_addr); end
        @(negedge clk); #1;
        n_chk++; if (a_push !== 4'b0001) begin n_fail++; $display("FAIL stall_push_after got=%0h exp=1", a_push); end
        n_chk++; if (a_if.glb_req !== 1'b0) begin n_fail++; $display("FAIL stall_inflight_req got=%0h exp=0", a_if.glb_req); end
        @(negedge clk); #1;
        n_chk++; if (a_if.glb_addr !== 32'h1004) begin n_fail++; $display("FAIL stall_second_addr got=%0h exp=1004", a_if.glb_addr); end
        for (int c = 0; c < 10; c++) begin
            if (a_done) seen++;
            @(negedge clk); #1;
        end
        n_chk++; if (seen !== 1) begin n_fail++; $display("FAIL stall_done got=%0d exp=1", seen); end
    endtask

    task automatic test_full_skip;
        logic [31:0] exp_addr [4] = '{32'h1000, 32'h1100, 32'h1300, 32'h1200};
        int          exp_ch   [4] = '{0, 1, 3, 2};
        int          k = 0;
        int          dones = 0;
        do_reset();
        a_full = 4'b0100;
        a_go(32'h1000, 32'h100, 16'd1, 4'hF);
        for (int c = 0; c < 15; c++) begin
            if (c == 3 || c == 5) begin
                n_chk++; if (a_if.glb_req !== 1'b0) begin n_fail++; $display("FAIL full_blocked_req c=%0d got=%0h exp=0", c, a_if.glb_req); end
            end
            if (a_if.glb_req && a_if.glb_ready) begin
                n_chk++;
                if (k >= 4) begin
                    n_fail++; $display("FAIL full_extra_accept c=%0d got=%0h exp=none", c, a_if.glb_addr);
                end else if (a_if.glb_addr !== exp_addr[k] || a_if.glb_ch_id !== 2'(exp_ch[k])) begin
                    n_fail++; $display("FAIL full_accept k=%0d got=%0h/%0d exp=%0h/%0d", k, a_if.glb_addr, a_if.glb_ch_id, exp_addr[k], exp_ch[k]);
                end
                k++;
            end
            if (a_done) dones++;
            @(negedge clk);
            if (c == 5) a_full = 4'b0000;
            #1;
        end
        n_chk++; if (k !== 4) begin n_fail++; $display("FAIL full_accept_count got=%0d exp=4", k); end
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL full_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_flush;
        logic [31:0] exp_addr [2] = '{32'h1100, 32'h1104};
        int          k = 0;
        int          dones = 0;
        logic        prev_acc = 1'b0;
        logic [3:0]  exp_push;
        do_reset();
        a_go(32'h1000, 32'h100, 16'd2, 4'b0010);
        n_chk++; if (a_if.glb_req !== 1'b1 || a_if.glb_addr !== 32'h1100) begin n_fail++; $display("FAIL flush_first got=%0h/%0h exp=1/1100", a_if.glb_req, a_if.glb_addr); end
        @(negedge clk);
        a_rst_i = 4'b0010;
        #1;
        n_chk++; if (a_push !== 4'b0000) begin n_fail++; $display("FAIL flush_push_suppress got=%0h exp=0", a_push); end
        n_chk++; if (a_if.glb_req !== 1'b0) begin n_fail++; $display("FAIL flush_req got=%0h exp=0", a_if.glb_req); end
        @(negedge clk);
        a_rst_i = 4'b0000;
        #1;
        for (int c = 0; c < 15; c++) begin
            exp_push = prev_acc ? 4'b0010 : 4'b0000;
            n_chk++; if (a_push !== exp_push) begin n_fail++; $display("FAIL flush_push c=%0d got=%0h exp=%0h", c, a_push, exp_push); end
            prev_acc = 1'b0;
            if (a_if.glb_req && a_if.glb_ready) begin
                n_chk++;
                if (k >= 2) begin
                    n_fail++; $display("FAIL flush_extra_accept c=%0d got=%0h exp=none", c, a_if.glb_addr);
                end else if (a_if.glb_addr !== exp_addr[k] || a_if.glb_ch_id !== 2'd1) begin
                    n_fail++; $display("FAIL flush_accept k=%0d got=%0h/%0d exp=%0h/1", k, a_if.glb_addr, a_if.glb_ch_id, exp_addr[k]);
                end
                prev_acc = 1'b1;
                k++;
            end
            if (a_done) dones++;
            @(negedge clk); #1;
        end
        n_chk++; if (k + 1 !== 3) begin n_fail++; $display("FAIL flush_total_accepts got=%0d exp=3", k + 1); end
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL flush_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_empty_cfg;
        logic [15:0] lens [2] = '{16'd2, 16'd0};
        logic [3:0]  ens  [2] = '{4'b0000, 4'b1111};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            a_go(32'h1000, 32'h100, lens[t], ens[t]);
            n_chk++; if (a_if.glb_req !== 1'b0 || a_busy !== 1'b1 || a_done !== 1'b0) begin n_fail++; $display("FAIL empty_s1 t=%0d got=%0h/%0h/%0h exp=0/1/0", t, a_if.glb_req, a_busy, a_done); end
            @(negedge clk); #1;
            n_chk++; if (a_if.glb_req !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL empty_s2 t=%0d got=%0h/%0h exp=0/0", t, a_if.glb_req, a_done); end
            @(negedge clk); #1;
            n_chk++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL empty_s3 t=%0d got=%0h/%0h exp=1/0", t, a_done, a_busy); end
            @(negedge clk); #1;
            n_chk++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL empty_s4 t=%0d got=%0h exp=0", t, a_done); end
        end
    endtask

    task automatic test_dir1;
        logic [31:0] exp_addr [6] = '{32'h2040, 32'h2044, 32'h2048,
                                      32'h2000, 32'h2004, 32'h2008};
        int          exp_ch   [6] = '{1, 1, 1, 0, 0, 0};
        int          k = 0;
        int          dones = 0;
        logic [1:0]  exp_pop;
        logic [3:0]  exp_web;
        do_reset();
        b_empty = 2'b01;
        b_web   = 8'hA5;
        b_go(32'h2000, 32'h40, 16'd3, 2'b11);
        for (int c = 0; c < 20; c++) begin
            if (b_if.glb_req) begin
                n_chk++;
                if (k >= 6) begin
                    n_fail++; $display("FAIL dir1_extra_accept c=%0d got=%0h exp=none", c, b_if.glb_addr);
                end else begin
                    exp_pop = (exp_ch[k] == 1) ? 2'b10 : 2'b01;
                    exp_web = (exp_ch[k] == 1) ? 4'hA : 4'h5;
                    if (b_if.glb_addr !== exp_addr[k] || b_if.glb_ch_id !== 1'(exp_ch[k])
                        || b_pop !== exp_pop || b_if.glb_web !== exp_web) begin
                        n_fail++; $display("FAIL dir1_accept k=%0d got=%0h/%0d/%0h/%0h exp=%0h/%0d/%0h/%0h",
                            k, b_if.glb_addr, b_if.glb_ch_id, b_pop, b_if.glb_web, exp_addr[k], exp_ch[k], exp_pop, exp_web);
                    end
                end
                k++;
            end else begin
                n_chk++; if (b_pop !== 2'b00 || b_if.glb_web !== 4'hF) begin n_fail++; $display("FAIL dir1_idle c=%0d got=%0h/%0h exp=0/f", c, b_pop, b_if.glb_web); end
            end
            if (c >= 3 && c <= 5) begin
                n_chk++; if (b_busy !== 1'b1 || b_done !== 1'b0) begin n_fail++; $display("FAIL dir1_hold c=%0d got=%0h/%0h exp=1/0", c, b_busy, b_done); end
            end
            if (b_done) dones++;
            @(negedge clk);
            if (c == 5) b_empty = 2'b00;
            #1;
        end
        n_chk++; if (k !== 6) begin n_fail++; $display("FAIL dir1_pop_count got=%0d exp=6", k); end
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL dir1_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_async_reset;
        do_reset();
        a_go(32'h1000, 32'h100, 16'd2, 4'hF);
        @(negedge clk); #1;
        n_chk++; if (a_push !== 4'b0001 || a_busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre got=%0h/%0h exp=1/1", a_push, a_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (a_if.glb_req !== 1'b0) begin n_fail++; $display("FAIL arst_req got=%0h exp=0", a_if.glb_req); end
        n_chk++; if (a_if.glb_addr !== 32'h0 || a_if.glb_ch_id !== 2'd0) begin n_fail++; $display("FAIL arst_addr got=%0h/%0h exp=0/0", a_if.glb_addr, a_if.glb_ch_id); end
        n_chk++; if (a_push !== 4'h0 || a_busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL arst_status got=%0h/%0h/%0h exp=0/0/0", a_push, a_busy, a_done); end
        n_chk++; if (a_if.glb_web !== 4'hF) begin n_fail++; $display("FAIL arst_web got=%0h exp=f", a_if.glb_web); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_defaults();
        rst_n = 1'b0;
        #2;
        test_reset();
        test_fill();
        test_ready_stall();
        test_full_skip();
        test_flush();
        test_empty_cfg();
        test_dir1();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
